// File: rtl/spi_cmd_controller_if.sv
// Bus between spi_cmd_controller and its neighbours: the SPI byte receiver,
// the image buffer write port and the inference core.
// byte_valid/byte_taken: the receiver holds spi_rx_data stable while
// byte_valid=1; the controller pulses byte_taken for one cycle in the cycle it
// samples the byte, and takes nothing more until byte_valid has been seen low.
interface spi_cmd_controller_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        spi_rx_data;
  logic              byte_valid;
  logic              byte_taken;
  logic              rx_enable;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              infer_start;
  logic              infer_done;
  logic              img_loaded;
  logic              err_cmd;
  logic              err_timeout;
  logic [1:0]        state_dbg;

  modport master (
    input  spi_rx_data, byte_valid, infer_done,
    output byte_taken, rx_enable, buf_we, buf_addr, buf_wdata,
           infer_start, img_loaded, err_cmd, err_timeout, state_dbg
  );

  modport slave (
    output spi_rx_data, byte_valid, infer_done,
    input  byte_taken, rx_enable, buf_we, buf_addr, buf_wdata,
           infer_start, img_loaded, err_cmd, err_timeout, state_dbg
  );
endinterface

// File: rtl/spi_cmd_controller.sv
// Command decoder between the SPI byte receiver and the image buffer /
// inference core: LOAD fills the buffer, START launches inference, CLEAR resets flags.
module spi_cmd_controller #(
  parameter int IMG_BYTES      = 128,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic                  clk,
  input logic                  rst,
  spi_cmd_controller_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_WAIT_CMD = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_INFER    = 2'd2;

  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_START = 8'h02;
  localparam logic [7:0] OP_CLEAR = 8'h03;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        r_state;
  logic              r_take_armed;
  logic [ADDR_W-1:0] r_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_rx_enable;
  logic              r_buf_we;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [7:0]        r_buf_wdata;
  logic              r_infer_start;
  logic              r_img_loaded;
  logic              r_err_cmd;
  logic              r_err_timeout;
  logic              w_accept;

  assign w_accept = ((r_state == S_WAIT_CMD) || (r_state == S_LOAD)) &&
                    bus.byte_valid && r_take_armed;

  // Gated by rst so every output reads 0 while reset is held.
  assign bus.byte_taken  = w_accept & ~rst;
  assign bus.rx_enable   = r_rx_enable;
  assign bus.buf_we      = r_buf_we;
  assign bus.buf_addr    = r_buf_addr;
  assign bus.buf_wdata   = r_buf_wdata;
  assign bus.infer_start = r_infer_start;
  assign bus.img_loaded  = r_img_loaded;
  assign bus.err_cmd     = r_err_cmd;
  assign bus.err_timeout = r_err_timeout;
  assign bus.state_dbg   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_WAIT_CMD;
      r_take_armed  <= 1'b1;
      r_cnt         <= '0;
      r_to_cnt      <= '0;
      r_rx_enable   <= 1'b0;
      r_buf_we      <= 1'b0;
      r_buf_addr    <= '0;
      r_buf_wdata   <= '0;
      r_infer_start <= 1'b0;
      r_img_loaded  <= 1'b0;
      r_err_cmd     <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_buf_we      <= 1'b0;
      r_infer_start <= 1'b0;
      r_rx_enable   <= 1'b1;

      // Re-arm only once byte_valid drops, so a late-falling valid is not taken twice.
      if (w_accept)
        r_take_armed <= 1'b0;
      else if (!bus.byte_valid)
        r_take_armed <= 1'b1;

      case (r_state)
        S_WAIT_CMD: begin
          if (w_accept) begin
            case (bus.spi_rx_data)
              OP_LOAD: begin
                r_img_loaded <= 1'b0;
                r_cnt        <= '0;
                r_to_cnt     <= '0;
                r_state      <= S_LOAD;
              end
              OP_START: begin
                if (r_img_loaded) begin
                  r_infer_start <= 1'b1;
                  r_rx_enable   <= 1'b0;
                  r_state       <= S_INFER;
                end else begin
                  r_err_cmd <= 1'b1;
                end
              end
              OP_CLEAR: begin
                r_err_cmd     <= 1'b0;
                r_err_timeout <= 1'b0;
                r_img_loaded  <= 1'b0;
              end
              default: r_err_cmd <= 1'b1;
            endcase
          end
        end

        S_LOAD: begin
          if (w_accept) begin
            r_buf_we    <= 1'b1;
            r_buf_addr  <= r_cnt;
            r_buf_wdata <= bus.spi_rx_data;
            r_to_cnt    <= '0;
            if (r_cnt == LAST_ADDR) begin
              r_img_loaded <= 1'b1;
              r_cnt        <= '0;
              r_state      <= S_WAIT_CMD;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Partial image is abandoned; buffer contents are not scrubbed.
            r_err_timeout <= 1'b1;
            r_img_loaded  <= 1'b0;
            r_cnt         <= '0;
            r_to_cnt      <= '0;
            r_state       <= S_WAIT_CMD;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_INFER: begin
          r_rx_enable <= bus.infer_done;
          if (bus.infer_done)
            r_state <= S_WAIT_CMD;
        end

        default: r_state <= S_WAIT_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: opcode table, full image load,
// inference launch, load timeout, held byte_valid and reset in mid-load.
module tb_spi_cmd_controller;

  localparam int IMG_BYTES = 128;
  localparam int ADDR_W    = 7;
  localparam int TMO       = 300;

  typedef struct {
    logic [7:0] cmd;
    logic       exp_take;
    logic       exp_err;
    logic [1:0] exp_state;
    int         exp_starts;
  } vec_t;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   n_start;
  logic [ADDR_W+7:0] exp_q[$];

  spi_cmd_controller_if #(.ADDR_W(ADDR_W)) bus ();

  spi_cmd_controller #(
    .IMG_BYTES     (IMG_BYTES),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every buffer write must match the next expected {addr, data}
  always @(negedge clk) begin
    if (!rst && bus.infer_start) n_start++;
    if (!rst && bus.buf_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", bus.buf_addr, bus.buf_wdata);
      end else begin
        logic [ADDR_W+7:0] e;
        e = exp_q.pop_front();
        chk("buf_addr", 32'(bus.buf_addr), 32'(e[ADDR_W+7:8]));
        chk("buf_wdata", 32'(bus.buf_wdata), 32'(e[7:0]));
        chk("img_loaded_at_write", 32'(bus.img_loaded), 32'(e[ADDR_W+7:8] == ADDR_W'(IMG_BYTES - 1)));
      end
    end
  end

  // Driver: present one byte, check the acknowledge, hold extra cycles, then drop valid
  task automatic send_byte(input logic [7:0] b, input logic exp_take, input int hold);
    @(negedge clk);
    bus.spi_rx_data = b;
    bus.byte_valid  = 1'b1;
    #1;
    chk("byte_taken", 32'(bus.byte_taken), 32'(exp_take));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("byte_taken_held", 32'(bus.byte_taken), 32'd0);
    end
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #1;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.infer_done = 1'b1;
    @(negedge clk);
    bus.infer_done = 1'b0;
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_taken"}, 32'(bus.byte_taken), 32'd0);
    chk({tag, "_rx_enable"}, 32'(bus.rx_enable), 32'd0);
    chk({tag, "_buf_we"}, 32'(bus.buf_we), 32'd0);
    chk({tag, "_buf_addr"}, 32'(bus.buf_addr), 32'd0);
    chk({tag, "_buf_wdata"}, 32'(bus.buf_wdata), 32'd0);
    chk({tag, "_infer_start"}, 32'(bus.infer_start), 32'd0);
    chk({tag, "_img_loaded"}, 32'(bus.img_loaded), 32'd0);
    chk({tag, "_err_cmd"}, 32'(bus.err_cmd), 32'd0);
    chk({tag, "_err_timeout"}, 32'(bus.err_timeout), 32'd0);
    chk({tag, "_state_dbg"}, 32'(bus.state_dbg), 32'd0);
  endtask

  initial begin
    vec_t vecs[8];
    int   s0;

    vecs[0] = '{cmd: 8'h02, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};
    vecs[1] = '{cmd: 8'h03, exp_take: 1'b1, exp_err: 1'b0, exp_state: 2'd0, exp_starts: 0};
    vecs[2] = '{cmd: 8'h7E, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};
    vecs[3] = '{cmd: 8'h00, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};
    vecs[4] = '{cmd: 8'hFF, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};
    vecs[5] = '{cmd: 8'h03, exp_take: 1'b1, exp_err: 1'b0, exp_state: 2'd0, exp_starts: 0};
    vecs[6] = '{cmd: 8'h02, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};
    vecs[7] = '{cmd: 8'h7E, exp_take: 1'b1, exp_err: 1'b1, exp_state: 2'd0, exp_starts: 0};

    n_vec           = 0;
    n_err           = 0;
    n_start         = 0;
    rst             = 1'b1;
    bus.spi_rx_data = 8'h00;
    bus.byte_valid  = 1'b0;
    bus.infer_done  = 1'b0;

    #1;
    chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_reset_state", 32'(bus.state_dbg), 32'd0);
    chk("post_reset_rx_enable", 32'(bus.rx_enable), 32'd1);

    // Opcode table, applied from an empty buffer
    for (int v = 0; v < 8; v++) begin
      s0 = n_start;
      send_byte(vecs[v].cmd, vecs[v].exp_take, 0);
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_err_cmd", v), 32'(bus.err_cmd), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_state", v), 32'(bus.state_dbg), 32'(vecs[v].exp_state));
      chk($sformatf("vec%0d_img_loaded", v), 32'(bus.img_loaded), 32'd0);
      chk($sformatf("vec%0d_infer_starts", v), 32'(n_start - s0), 32'(vecs[v].exp_starts));
    end

    // Full image load after a bad opcode; bytes 0x01..0x03 are data here
    send_byte(8'h01, 1'b1, 0);
    chk("load_state", 32'(bus.state_dbg), 32'd1);
    chk("load_err_cmd_sticky", 32'(bus.err_cmd), 32'd1);
    for (int i = 0; i < IMG_BYTES; i++) begin
      exp_q.push_back({ADDR_W'(i), 8'(i)});
      send_byte(8'(i), 1'b1, 0);
      if (i == IMG_BYTES - 2) begin
        chk("load_pre_last_img_loaded", 32'(bus.img_loaded), 32'd0);
        chk("load_pre_last_state", 32'(bus.state_dbg), 32'd1);
      end
    end
    chk("load_done_state", 32'(bus.state_dbg), 32'd0);
    chk("load_done_img_loaded", 32'(bus.img_loaded), 32'd1);
    chk("load_writes_drained", 32'(exp_q.size()), 32'd0);

    // START, a byte ignored during INFER, completion, then a repeated START
    for (int r = 0; r < 2; r++) begin
      s0 = n_start;
      send_byte(8'h02, 1'b1, 0);
      chk("start_state", 32'(bus.state_dbg), 32'd2);
      chk("start_rx_enable", 32'(bus.rx_enable), 32'd0);
      send_byte(8'h55, 1'b0, 0);
      chk("infer_hold_state", 32'(bus.state_dbg), 32'd2);
      pulse_done();
      chk("done_state", 32'(bus.state_dbg), 32'd0);
      chk("done_rx_enable", 32'(bus.rx_enable), 32'd1);
      chk("done_img_loaded", 32'(bus.img_loaded), 32'd1);
      chk("start_pulse_count", 32'(n_start - s0), 32'd1);
    end

    // infer_done outside INFER has no effect
    s0 = n_start;
    pulse_done();
    chk("stray_done_state", 32'(bus.state_dbg), 32'd0);
    chk("stray_done_starts", 32'(n_start - s0), 32'd0);

    // Partial load then silence: timeout fires exactly TMO cycles after the last accept
    send_byte(8'h01, 1'b1, 0);
    chk("reload_img_cleared", 32'(bus.img_loaded), 32'd0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({ADDR_W'(i), 8'(8'hA0 + i)});
      send_byte(8'(8'hA0 + i), 1'b1, 0);
    end
    repeat (TMO - 1) @(negedge clk);
    #1;
    chk("timeout_early_err", 32'(bus.err_timeout), 32'd0);
    chk("timeout_early_state", 32'(bus.state_dbg), 32'd1);
    @(negedge clk);
    #1;
    chk("timeout_err", 32'(bus.err_timeout), 32'd1);
    chk("timeout_state", 32'(bus.state_dbg), 32'd0);
    chk("timeout_img_loaded", 32'(bus.img_loaded), 32'd0);
    send_byte(8'h03, 1'b1, 0);
    chk("clear_err_timeout", 32'(bus.err_timeout), 32'd0);
    chk("clear_err_cmd", 32'(bus.err_cmd), 32'd0);

    // Restart at address 0, then a byte held valid for 3 extra cycles
    send_byte(8'h01, 1'b1, 0);
    exp_q.push_back({ADDR_W'(0), 8'hC0});
    send_byte(8'hC0, 1'b1, 0);
    exp_q.push_back({ADDR_W'(1), 8'hC1});
    send_byte(8'hC1, 1'b1, 0);
    exp_q.push_back({ADDR_W'(2), 8'h5A});
    send_byte(8'h5A, 1'b1, 3);
    chk("held_valid_writes_drained", 32'(exp_q.size()), 32'd0);
    chk("held_valid_state", 32'(bus.state_dbg), 32'd1);
    for (int i = 3; i < 50; i++) begin
      exp_q.push_back({ADDR_W'(i), 8'(i) ^ 8'h3C});
      send_byte(8'(i) ^ 8'h3C, 1'b1, 0);
    end

    // Reset lands while byte 50 is being offered
    @(negedge clk);
    bus.spi_rx_data = 8'h99;
    bus.byte_valid  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("midload_reset");
    repeat (2) @(negedge clk);
    bus.byte_valid = 1'b0;
    rst            = 1'b0;
    @(negedge clk);
    #1;
    chk("after_reset_state", 32'(bus.state_dbg), 32'd0);
    chk("after_reset_rx_enable", 32'(bus.rx_enable), 32'd1);
    chk("after_reset_img_loaded", 32'(bus.img_loaded), 32'd0);
    chk("after_reset_queue", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_cmd_controller.md
Name: spi_cmd_controller

Overview:
- Sequences `spi_peripheral`: drives `rx_enable` and consumes received bytes over the `byte_valid`/`byte_taken` handshake.
- Decodes a one-byte command protocol. Loads image bytes into the image buffer write port and launches BNN inference.
- Sits between `spi_peripheral` and the image buffer / inference core; it is the only agent that writes the image buffer.

Parameters:
- IMG_BYTES, 128, number of image bytes per LOAD (32x32 binary image, 8 px/byte, MSB first).
- ADDR_W, 7, image buffer address width; must satisfy 2**ADDR_W >= IMG_BYTES.
- TIMEOUT_CYCLES, 100000, max idle clk cycles between bytes inside a LOAD before abort.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- spi_rx_data  in  8  byte from `spi_peripheral`; valid while byte_valid=1.
- byte_valid  in  1  byte ready from `spi_peripheral`.
- byte_taken  out  1  one-cycle acknowledge to `spi_peripheral`.
- rx_enable  out  1  permits `spi_peripheral` reception.
- buf_we  out  1  image buffer write strobe (one cycle per byte).
- buf_addr  out  ADDR_W  image buffer write address.
- buf_wdata  out  8  image buffer write data.
- infer_start  out  1  one-cycle inference launch pulse.
- infer_done  in  1  one-cycle pulse from inference core at completion.
- img_loaded  out  1  a complete image is present in the buffer.
- err_cmd  out  1  sticky: illegal opcode, or START with no image.
- err_timeout  out  1  sticky: LOAD aborted by timeout.
- state_dbg  out  2  current FSM state encoding.

Behaviour:
- Reset (async, rst=1): state=WAIT_CMD; all outputs 0; byte counter=0; timeout counter=0; take_armed=1.
- Commands: 0x01 LOAD, 0x02 START, 0x03 CLEAR. Any other opcode sets err_cmd.
- States:
  - WAIT_CMD=0: rx_enable=1; waits for a command byte.
  - LOAD=1: rx_enable=1; receives image bytes.
  - INFER=2: rx_enable=0; waits for infer_done.
- Byte accept rule:
  - Accept when state is WAIT_CMD or LOAD, byte_valid=1, and take_armed=1.
  - On accept: byte_taken=1 for exactly that cycle; spi_rx_data is sampled that cycle; take_armed clears.
  - take_armed sets again on the first cycle byte_valid=0. This guards against re-accepting the same byte while byte_valid falls 1-2 cycles late.
  - byte_taken is never asserted for two consecutive cycles.
- WAIT_CMD on accepted byte:
  - LOAD: img_loaded<=0, byte counter<=0, timeout counter<=0, go LOAD.
  - START with img_loaded=1: infer_start=1 next cycle (one cycle), go INFER.
  - START with img_loaded=0: err_cmd<=1, stay in WAIT_CMD.
  - CLEAR: err_cmd<=0, err_timeout<=0, img_loaded<=0, stay in WAIT_CMD.
  - Other opcode: err_cmd<=1, stay in WAIT_CMD.
- LOAD:
  - Each accepted byte produces buf_we=1, buf_addr=counter, buf_wdata=byte one cycle after accept (registered). Counter then increments.
  - When the byte at counter=IMG_BYTES-1 is written: img_loaded<=1 in the same cycle as that buf_we; go WAIT_CMD.
  - Bytes in LOAD are data, not decoded as opcodes (0x01..0x03 included).
  - Timeout counter increments every cycle in LOAD and clears on accept.
  - At TIMEOUT_CYCLES: err_timeout<=1, img_loaded<=0, counter<=0, go WAIT_CMD. Already-written buffer contents are left as is.
- INFER:
  - No bytes accepted; byte_valid is ignored and byte_taken=0.
  - infer_done=1 returns to WAIT_CMD next cycle; img_loaded stays 1, so a repeated START re-runs inference.
- Simultaneous events:
  - Accept and timeout-threshold in the same cycle: the accept wins and the timeout counter clears.
  - infer_done outside INFER is ignored.
- Reset mid-LOAD or mid-INFER: immediate return to WAIT_CMD with all outputs 0; any partial image is invalid (img_loaded=0).

Test Plan:
- Reset, then LOAD (0x01) followed by 128 bytes 0x00..0x7F -> 128 buf_we pulses at addr 0..127 with wdata=addr; img_loaded=1 at the last write; state_dbg=0.
- START (0x02) after a loaded image -> single infer_start pulse; state_dbg=2; a byte sent while in INFER gets no byte_taken; infer_done -> state_dbg=0.
- START immediately after reset -> err_cmd=1, no infer_start; then CLEAR (0x03) -> err_cmd=0.
- Opcode 0x7E -> err_cmd=1; state remains WAIT_CMD; next valid LOAD proceeds normally.
- LOAD followed by 10 bytes, then silence for TIMEOUT_CYCLES -> err_timeout=1, img_loaded=0, state_dbg=0; next LOAD restarts at addr 0.
- Hold byte_valid high for 3 cycles after byte_taken -> exactly one byte_taken and one buf_we; assert rst mid-LOAD at byte 50 -> all outputs 0, img_loaded=0.
